// File: rtl/bscan_cmd_engine.sv
// Scan-stream command engine: decodes 32-bit header/data words into single-word
// bus reads and writes with auto-incrementing addresses, and returns read data, acks and status.
`timescale 1ns/1ps

module bscan_cmd_engine #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              in_enq__ENA,
    input  logic [WIDTH-1:0]  in_enq_v,
    output logic              in_enq__RDY,
    output logic              out_enq__ENA,
    output logic [WIDTH-1:0]  out_enq_v,
    input  logic              out_enq__RDY,
    output logic              req_enq__ENA,
    output logic              req_enq_write,
    output logic [ADDR_W-1:0] req_enq_addr,
    output logic [WIDTH-1:0]  req_enq_data,
    input  logic              req_enq__RDY,
    input  logic              rsp_enq__ENA,
    input  logic [WIDTH-1:0]  rsp_enq_v,
    output logic              rsp_enq__RDY
);

    localparam int unsigned CNT_W  = 14;
    localparam int unsigned CMDC_W = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WDATA = 3'd1,
        S_WACK  = 3'd2,
        S_RREQ  = 3'd3,
        S_RWAIT = 3'd4,
        S_STAT  = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CMDC_W-1:0]   cmd_count_q, cmd_count_d;

    // State and datapath registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            cmd_count_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            cmd_count_q <= cmd_count_d;
        end
    end

    // Next-state and stream handshakes; data outputs stay 0 whenever their ENA is low
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rem_d         = rem_q;
        cnt_d         = cnt_q;
        cmd_count_d   = cmd_count_q;
        in_enq__RDY   = 1'b0;
        out_enq__ENA  = 1'b0;
        out_enq_v     = '0;
        req_enq__ENA  = 1'b0;
        req_enq_write = 1'b0;
        req_enq_addr  = '0;
        req_enq_data  = '0;
        rsp_enq__RDY  = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_enq__RDY = 1'b1;
                if (in_enq__ENA) begin
                    addr_d = in_enq_v[ADDR_W-1:0];
                    rem_d  = in_enq_v[29:16];
                    cnt_d  = in_enq_v[29:16];
                    case (in_enq_v[31:30])
                        2'd0:    cmd_count_d = cmd_count_q + CMDC_W'(1);
                        2'd1:    state_d = S_WDATA;
                        2'd2:    state_d = S_RREQ;
                        default: state_d = S_STAT;
                    endcase
                end
            end

            S_WDATA: begin
                in_enq__RDY  = req_enq__RDY;
                req_enq__ENA = in_enq__ENA;
                if (in_enq__ENA) begin
                    req_enq_write = 1'b1;
                    req_enq_addr  = addr_q;
                    req_enq_data  = in_enq_v;
                end
                if (in_enq__ENA && req_enq__RDY) begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (rem_q == '0) begin
                        state_d = S_WACK;
                    end else begin
                        rem_d = rem_q - CNT_W'(1);
                    end
                end
            end

            S_WACK: begin
                out_enq__ENA = 1'b1;
                out_enq_v    = {2'b01, cnt_q, addr_q};
                if (out_enq__RDY) begin
                    state_d     = S_IDLE;
                    cmd_count_d = cmd_count_q + CMDC_W'(1);
                end
            end

            S_RREQ: begin
                req_enq__ENA = 1'b1;
                req_enq_addr = addr_q;
                if (req_enq__RDY) begin
                    state_d = S_RWAIT;
                end
            end

            S_RWAIT: begin
                rsp_enq__RDY = out_enq__RDY;
                out_enq__ENA = rsp_enq__ENA;
                if (rsp_enq__ENA) begin
                    out_enq_v = rsp_enq_v;
                end
                if (rsp_enq__ENA && out_enq__RDY) begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (rem_q == '0) begin
                        state_d     = S_IDLE;
                        cmd_count_d = cmd_count_q + CMDC_W'(1);
                    end else begin
                        rem_d   = rem_q - CNT_W'(1);
                        state_d = S_RREQ;
                    end
                end
            end

            S_STAT: begin
                out_enq__ENA = 1'b1;
                out_enq_v    = {8'hA5, 8'h00, cmd_count_q};
                if (out_enq__RDY) begin
                    state_d     = S_IDLE;
                    cmd_count_d = cmd_count_q + CMDC_W'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_bscan_cmd_engine.sv
// Testbench for bscan_cmd_engine: directed command table, hand-timed corner sequences,
// and randomized traffic scored against a command-level model of the bus and memory.
`timescale 1ns/1ps

module tb_bscan_cmd_engine;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        in_enq__ENA;
    logic [31:0] in_enq_v;
    logic        in_enq__RDY;
    logic        out_enq__ENA;
    logic [31:0] out_enq_v;
    logic        out_enq__RDY;
    logic        req_enq__ENA;
    logic        req_enq_write;
    logic [15:0] req_enq_addr;
    logic [31:0] req_enq_data;
    logic        req_enq__RDY;
    logic        rsp_enq__ENA;
    logic [31:0] rsp_enq_v;
    logic        rsp_enq__RDY;

    bscan_cmd_engine dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .in_enq__ENA  (in_enq__ENA),
        .in_enq_v     (in_enq_v),
        .in_enq__RDY  (in_enq__RDY),
        .out_enq__ENA (out_enq__ENA),
        .out_enq_v    (out_enq_v),
        .out_enq__RDY (out_enq__RDY),
        .req_enq__ENA (req_enq__ENA),
        .req_enq_write(req_enq_write),
        .req_enq_addr (req_enq_addr),
        .req_enq_data (req_enq_data),
        .req_enq__RDY (req_enq__RDY),
        .rsp_enq__ENA (rsp_enq__ENA),
        .rsp_enq_v    (rsp_enq_v),
        .rsp_enq__RDY (rsp_enq__RDY)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] data;
    } req_t;

    typedef struct {
        logic [31:0] hdr;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] exp_last;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_wr     = 0;
    logic [15:0] mdl_count;
    logic [31:0] last_out;
    logic [31:0] bus_mem [65536];
    logic [31:0] mdl_mem [65536];
    logic [31:0] in_q [$];
    logic [31:0] wdata_q [$];
    logic [31:0] exp_out [$];
    logic [31:0] rsp_pend [$];
    req_t        exp_req [$];
    vec_t        tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic pct(input int p);
        return int'($urandom_range(99, 0)) < p;
    endfunction

    task automatic idle_inputs();
        in_enq__ENA  = 1'b0;
        in_enq_v     = '0;
        req_enq__RDY = 1'b0;
        rsp_enq__ENA = 1'b0;
        rsp_enq_v    = '0;
        out_enq__RDY = 1'b0;
    endtask

    // Command-level model: queue the words to send and the bus/scan traffic the command implies
    task automatic add_cmd(input logic [31:0] hdr);
        logic [15:0] a;
        logic [31:0] d;
        int          n;
        a = hdr[15:0];
        n = int'(hdr[29:16]) + 1;
        in_q.push_back(hdr);
        case (hdr[31:30])
            2'd0: mdl_count++;
            2'd1: begin
                for (int i = 0; i < n; i++) begin
                    d = (wdata_q.size() != 0) ? wdata_q.pop_front() : $urandom();
                    in_q.push_back(d);
                    exp_req.push_back('{wr: 1'b1, addr: a, data: d});
                    mdl_mem[a] = d;
                    a++;
                end
                exp_out.push_back({2'b01, hdr[29:16], a});
                mdl_count++;
            end
            2'd2: begin
                for (int i = 0; i < n; i++) begin
                    exp_req.push_back('{wr: 1'b0, addr: a, data: 32'h0});
                    exp_out.push_back(mdl_mem[a]);
                    a++;
                end
                mdl_count++;
            end
            default: begin
                exp_out.push_back({8'hA5, 8'h00, mdl_count});
                mdl_count++;
            end
        endcase
    endtask

    // Drive queued words with the given per-stream readiness percentages and score every transfer
    task automatic run_traffic(input int p_in, input int p_req, input int p_rsp, input int p_out,
                               input int budget);
        int   cyc;
        req_t e;
        cyc = 0;
        while ((in_q.size() != 0 || exp_req.size() != 0 || exp_out.size() != 0) && cyc < budget) begin
            @(negedge CLK);
            in_enq__ENA  = (in_q.size() != 0) && pct(p_in);
            in_enq_v     = in_enq__ENA ? in_q[0] : $urandom();
            req_enq__RDY = pct(p_req);
            rsp_enq__ENA = (rsp_pend.size() != 0) && pct(p_rsp);
            rsp_enq_v    = rsp_enq__ENA ? rsp_pend[0] : 32'h0;
            out_enq__RDY = pct(p_out);
            #1;
            if (in_enq__ENA && in_enq__RDY) void'(in_q.pop_front());
            if (req_enq__ENA && req_enq__RDY) begin
                if (exp_req.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL req_extra: got addr %h wr %0b, none expected", req_enq_addr, req_enq_write);
                end else begin
                    e = exp_req.pop_front();
                    check("req_write", 32'(req_enq_write), 32'(e.wr));
                    check("req_addr", 32'(req_enq_addr), 32'(e.addr));
                    check("req_data", req_enq_data, e.data);
                end
                if (req_enq_write) begin
                    bus_mem[req_enq_addr] = req_enq_data;
                    n_wr++;
                end else begin
                    rsp_pend.push_back(bus_mem[req_enq_addr]);
                end
            end
            if (rsp_enq__ENA && rsp_enq__RDY) void'(rsp_pend.pop_front());
            if (out_enq__ENA && out_enq__RDY) begin
                if (exp_out.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out_extra: got %h, none expected", out_enq_v);
                end else begin
                    check("out_word", out_enq_v, exp_out.pop_front());
                end
                last_out = out_enq_v;
            end
            cyc++;
        end
        check("traffic_timeout", 32'(cyc >= budget), 32'h0);
        @(negedge CLK);
        idle_inputs();
        check("rsp_pending", 32'(rsp_pend.size()), 32'h0);
    endtask

    initial begin
        logic [31:0] wd [3];
        logic [31:0] hdr;
        logic [15:0] a;

        tbl[0] = '{32'h0000_0000, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF};
        tbl[1] = '{32'hC000_0000, 32'h0, 32'h0, 32'h0, 32'hA500_0002};
        tbl[2] = '{32'h4002_1000, 32'h11, 32'h22, 32'h33, 32'h4002_1003};
        tbl[3] = '{32'h8001_FFFF, 32'h0, 32'h0, 32'h0, 32'h0000_BEEF};
        tbl[4] = '{32'hC000_0000, 32'h0, 32'h0, 32'h0, 32'hA500_0005};

        for (int i = 0; i < 65536; i++) begin
            bus_mem[i] = 32'h0;
            mdl_mem[i] = 32'h0;
        end
        bus_mem[16'hFFFF] = 32'hDEAD; mdl_mem[16'hFFFF] = 32'hDEAD;
        bus_mem[16'h0000] = 32'hBEEF; mdl_mem[16'h0000] = 32'hBEEF;
        mdl_count = '0;
        last_out  = '0;

        // Reset values, during and after reset
        nRST = 1'b0;
        idle_inputs();
        repeat (2) @(negedge CLK);
        #1;
        check("rst_in_rdy", 32'(in_enq__RDY), 32'h1);
        check("rst_out_ena", 32'(out_enq__ENA), 32'h0);
        check("rst_req_ena", 32'(req_enq__ENA), 32'h0);
        check("rst_rsp_rdy", 32'(rsp_enq__RDY), 32'h0);
        check("rst_out_v", out_enq_v, 32'h0);
        check("rst_req_addr", 32'(req_enq_addr), 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        check("post_rst_in_rdy", 32'(in_enq__RDY), 32'h1);
        check("post_rst_req_ena", 32'(req_enq__ENA), 32'h0);

        // STATUS right after reset: status word one cycle after the header
        @(negedge CLK);
        in_enq__ENA = 1'b1; in_enq_v = 32'hC000_0000; out_enq__RDY = 1'b1;
        #1;
        check("stat_hdr_rdy", 32'(in_enq__RDY), 32'h1);
        check("stat_hdr_out_ena", 32'(out_enq__ENA), 32'h0);
        @(negedge CLK);
        in_enq__ENA = 1'b0;
        #1;
        check("stat_out_ena", 32'(out_enq__ENA), 32'h1);
        check("stat_out_v", out_enq_v, 32'hA500_0000);
        @(negedge CLK);
        #1;
        check("stat_done_out_ena", 32'(out_enq__ENA), 32'h0);
        idle_inputs();
        mdl_count++;

        // Directed command table
        for (int i = 0; i < 5; i++) begin
            wdata_q.delete();
            wdata_q.push_back(tbl[i].d0);
            wdata_q.push_back(tbl[i].d1);
            wdata_q.push_back(tbl[i].d2);
            if (tbl[i].hdr[31:30] != 2'd1) wdata_q.delete();
            add_cmd(tbl[i].hdr);
            last_out = 32'hFFFF_FFFF;
            run_traffic(100, 100, 100, 100, 200);
            check($sformatf("tbl%0d_last_out", i), last_out, tbl[i].exp_last);
        end

        // WRITE pass-through timing: one write per cycle, ack the cycle after the last data
        wd = '{32'h0000_000A, 32'h0000_000B, 32'h0000_000C};
        @(negedge CLK);
        in_enq__ENA = 1'b1; in_enq_v = 32'h4002_2000; req_enq__RDY = 1'b1; out_enq__RDY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            in_enq_v = wd[i];
            #1;
            a = 16'(16'h2000 + i);
            check("wr_req_ena", 32'(req_enq__ENA), 32'h1);
            check("wr_req_write", 32'(req_enq_write), 32'h1);
            check("wr_req_addr", 32'(req_enq_addr), 32'(a));
            check("wr_req_data", req_enq_data, wd[i]);
            check("wr_in_rdy", 32'(in_enq__RDY), 32'h1);
            bus_mem[a] = wd[i];
            mdl_mem[a] = wd[i];
        end
        @(negedge CLK);
        in_enq__ENA = 1'b0;
        #1;
        check("wr_ack_ena", 32'(out_enq__ENA), 32'h1);
        check("wr_ack_v", out_enq_v, 32'h4002_2003);
        @(negedge CLK);
        #1;
        check("wr_ack_done", 32'(out_enq__ENA), 32'h0);
        idle_inputs();
        mdl_count++;

        // READ with scan-side backpressure for 5 cycles while response is presented
        @(negedge CLK);
        in_enq__ENA = 1'b1; in_enq_v = 32'h8000_0040; req_enq__RDY = 1'b1;
        @(negedge CLK);
        in_enq__ENA = 1'b0;
        #1;
        check("rd_req_ena", 32'(req_enq__ENA), 32'h1);
        check("rd_req_addr", 32'(req_enq_addr), 32'h40);
        check("rd_req_write", 32'(req_enq_write), 32'h0);
        check("rd_req_data", req_enq_data, 32'h0);
        @(negedge CLK);
        rsp_enq__ENA = 1'b1; rsp_enq_v = 32'hCAFE_0001; out_enq__RDY = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_rsp_rdy", 32'(rsp_enq__RDY), 32'h0);
            check("bp_out_ena", 32'(out_enq__ENA), 32'h1);
            check("bp_out_v", out_enq_v, 32'hCAFE_0001);
            check("bp_req_ena", 32'(req_enq__ENA), 32'h0);
            @(negedge CLK);
        end
        out_enq__RDY = 1'b1;
        #1;
        check("bp_rsp_rdy_rel", 32'(rsp_enq__RDY), 32'h1);
        check("bp_out_v_rel", out_enq_v, 32'hCAFE_0001);
        @(negedge CLK);
        rsp_enq__ENA = 1'b0;
        #1;
        check("bp_done_out_ena", 32'(out_enq__ENA), 32'h0);
        check("bp_done_req_ena", 32'(req_enq__ENA), 32'h0);
        check("bp_done_in_rdy", 32'(in_enq__RDY), 32'h1);
        idle_inputs();
        mdl_count++;

        // Randomized command mix with random handshakes on every stream
        for (int k = 0; k < 40; k++) begin
            a = ($urandom_range(3, 0) == 0) ? 16'(16'hFFFC + $urandom_range(3, 0)) : 16'($urandom());
            hdr = {2'($urandom_range(3, 0)), 14'($urandom_range(5, 0)), a};
            add_cmd(hdr);
        end
        run_traffic(70, 60, 60, 70, 20000);

        // 16-word WRITE under random bus stalls
        n_wr = 0;
        add_cmd({2'b01, 14'd15, 16'h3000});
        run_traffic(100, 40, 100, 100, 2000);
        check("burst16_writes", 32'(n_wr), 32'd16);

        // Reset after the 2nd of 4 WRITE data words abandons the command
        @(negedge CLK);
        in_enq__ENA = 1'b1; in_enq_v = 32'h4003_0100; req_enq__RDY = 1'b1; out_enq__RDY = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            in_enq_v = 32'h0E00 + 32'(i);
            #1;
            a = 16'(16'h0100 + i);
            check("abort_req_addr", 32'(req_enq_addr), 32'(a));
            bus_mem[a] = in_enq_v;
            mdl_mem[a] = in_enq_v;
        end
        @(negedge CLK);
        in_enq__ENA = 1'b0;
        nRST = 1'b0;
        #1;
        check("abort_in_rdy", 32'(in_enq__RDY), 32'h1);
        check("abort_req_ena", 32'(req_enq__ENA), 32'h0);
        check("abort_out_ena", 32'(out_enq__ENA), 32'h0);
        check("abort_rsp_rdy", 32'(rsp_enq__RDY), 32'h0);
        check("abort_req_addr0", 32'(req_enq_addr), 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        idle_inputs();
        mdl_count = '0;
        add_cmd(32'hC000_0000);
        last_out = 32'hFFFF_FFFF;
        run_traffic(100, 100, 100, 100, 200);
        check("abort_status", last_out, 32'hA500_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
